// File: rtl/serial_par_1x8_pkg.sv
// Shared constants and state encoding for the 1-to-8 serial deserialiser.
// No logic here; imported by serial_par_1x8.
package serial_par_1x8_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic is_comma(input logic [BYTE_W-1:0] b, input logic [BYTE_W-1:0] comma);
        return b == comma;
    endfunction

endpackage

// File: rtl/serial_par_1x8.sv
// Comma-aligned 1-to-8 deserialiser; optional comma counter under SERPAR_BC_COUNT_EN.
// Byte registered on the edge sampling its last bit, held 8 edges; no backpressure (free-running link).
module serial_par_1x8
    import serial_par_1x8_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA         = COMMA_DEFAULT,
    parameter int unsigned       BC_LOCK_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              byte_strobe,
    output logic              active
`ifdef SERPAR_BC_COUNT_EN
    ,
    output logic [7:0]        bc_count
`endif
);

    localparam logic [2:0] LOCK_CNT = BC_LOCK_COUNT[2:0];

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] shift_q;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]        bc_cnt_q, bc_cnt_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              strobe_q, strobe_d;
    logic              active_q, active_d;

    logic [BYTE_W-1:0] new_byte;
    logic              byte_done;
    logic              comma_hit;
    logic [2:0]        bc_inc;

    assign new_byte  = {shift_q[BYTE_W-2:0], data_in};
    assign byte_done = (bit_cnt_q == 3'd7);
    assign comma_hit = is_comma(new_byte, COMMA);
    assign bc_inc    = bc_cnt_q + 3'd1;

`ifdef SERPAR_BC_COUNT_EN
    logic [7:0] bc_count_q, bc_count_d;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;
        active_d  = active_q;
`ifdef SERPAR_BC_COUNT_EN
        bc_count_d = bc_count_q;
`endif
        case (state_q)
            SEARCH: begin
                // Any bit phase may hit; a hit defines the byte boundary.
                if (comma_hit) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = 3'd1;
                    if (LOCK_CNT == 3'd1) begin
                        state_d  = LOCKED;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (byte_done) begin
                    if (comma_hit) begin
                        bc_cnt_d = bc_inc;
                        if (bc_inc == LOCK_CNT) begin
                            state_d  = LOCKED;
                            active_d = 1'b1;
                        end
                    end else begin
                        state_d  = SEARCH;
                        bc_cnt_d = 3'd0;
                    end
                end
            end
            LOCKED: begin
                if (byte_done) begin
                    data_d   = new_byte;
                    valid_d  = !comma_hit;
                    strobe_d = 1'b1;
`ifdef SERPAR_BC_COUNT_EN
                    if (comma_hit && (bc_count_q != 8'hFF)) begin
                        bc_count_d = bc_count_q + 8'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state_q   <= SEARCH;
            shift_q   <= '0;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 3'd0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
`ifdef SERPAR_BC_COUNT_EN
            bc_count_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= new_byte;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
`ifdef SERPAR_BC_COUNT_EN
            bc_count_q <= bc_count_d;
`endif
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;
`ifdef SERPAR_BC_COUNT_EN
    assign bc_count    = bc_count_q;
`endif

endmodule

// File: tb/tb_serial_par_1x8.sv
// Scoreboard bench for serial_par_1x8: lock count 4 and lock count 1 instances share one stream.
// Expected bytes come from a whole-stream comma scan; a monitor pops them on byte_strobe.
module tb_serial_par_1x8;

    localparam logic [7:0] COMMA = 8'hBC;

    typedef struct {
        int         eidx;
        logic [7:0] dat;
        logic       vld;
    } exp_t;

    logic clk_32f = 1'b0;
    logic reset_L = 1'b0;
    logic data_in = 1'b0;

    logic [1:0][7:0] dout;
    logic [1:0]      vld;
    logic [1:0]      strb;
    logic [1:0]      act;
`ifdef SERPAR_BC_COUNT_EN
    logic [1:0][7:0] bcc;
`endif

    always #5 clk_32f = ~clk_32f;

    serial_par_1x8 #(.COMMA(COMMA), .BC_LOCK_COUNT(4)) dut4 (
        .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in),
        .data_out(dout[0]), .valid_out(vld[0]), .byte_strobe(strb[0]), .active(act[0])
`ifdef SERPAR_BC_COUNT_EN
        , .bc_count(bcc[0])
`endif
    );

    serial_par_1x8 #(.COMMA(COMMA), .BC_LOCK_COUNT(1)) dut1 (
        .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in),
        .data_out(dout[1]), .valid_out(vld[1]), .byte_strobe(strb[1]), .active(act[1])
`ifdef SERPAR_BC_COUNT_EN
        , .bc_count(bcc[1])
`endif
    );

    int   checks = 0;
    int   errors = 0;
    bit   stream[$];
    exp_t tmp_q[$];
    exp_t q0[$];
    exp_t q1[$];
    int   lock_e[2];
    int   k = 0;
    logic [7:0] hd[2];
    logic       hv[2];
    int         hc[2];

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d edge %0d: got %h expected %h", nm, d, k, got, want);
        end
    endtask

    // Byte ending at bit index e; bits before the stream start read as 0 (cleared shifter).
    function automatic logic [7:0] byte_at(input int e);
        logic [7:0] b = 8'h00;
        for (int j = 0; j < 8; j++) begin
            int p = e - 7 + j;
            b = {b[6:0], (p >= 0) ? stream[p] : 1'b0};
        end
        return b;
    endfunction

    task automatic run_model(input int lock_n, output int le);
        int  n = stream.size();
        int  pos = 0;
        int  i;
        int  cnt;
        bit  done = 0;
        bit  broke;
        le = -1;
        tmp_q.delete();
        while (!done) begin
            i = pos;
            while (i < n && byte_at(i) != COMMA) i++;
            if (i >= n) begin
                done = 1;
            end else begin
                cnt = 1;
                broke = 0;
                while (cnt < lock_n && !broke && !done) begin
                    i += 8;
                    if (i >= n) done = 1;
                    else if (byte_at(i) == COMMA) cnt++;
                    else begin broke = 1; pos = i + 1; end
                end
                if (!broke && !done) begin
                    le = i;
                    done = 1;
                end
            end
        end
        if (le >= 0) begin
            for (int p = le + 8; p < n; p += 8) begin
                exp_t e;
                e.eidx = p;
                e.dat  = byte_at(p);
                e.vld  = (byte_at(p) != COMMA);
                tmp_q.push_back(e);
            end
        end
    endtask

    task automatic add_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
    endtask

    task automatic add_byte(input logic [7:0] b);
        add_bits({24'h0, b}, 8);
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk_32f);
            reset_L = 1'b0;
            data_in = 1'($urandom);
        end
    endtask

    task automatic play();
        int le;
        @(negedge clk_32f);
        run_model(4, le);
        q0 = tmp_q;
        lock_e[0] = le;
        run_model(1, le);
        q1 = tmp_q;
        lock_e[1] = le;
        reset_L = 1'b1;
        data_in = stream[0];
        for (int i = 1; i < stream.size(); i++) begin
            @(negedge clk_32f);
            data_in = stream[i];
        end
        stream.delete();
    endtask

    task automatic check_inst(input int d, input logic r);
        exp_t e;
        bit   have = 0;
        bit   exp_s;
        if (!r) begin
            chk("rst_data", d, {24'h0, dout[d]}, 32'h0);
            chk("rst_valid", d, {31'h0, vld[d]}, 32'h0);
            chk("rst_strobe", d, {31'h0, strb[d]}, 32'h0);
            chk("rst_active", d, {31'h0, act[d]}, 32'h0);
            chk("pending_bytes", d, (d == 0) ? q0.size() : q1.size(), 32'h0);
            if (d == 0) q0.delete(); else q1.delete();
            hd[d] = 8'h00;
            hv[d] = 1'b0;
            hc[d] = 0;
        end else begin
            if (d == 0 && q0.size() > 0) begin have = 1; e = q0[0]; end
            if (d == 1 && q1.size() > 0) begin have = 1; e = q1[0]; end
            exp_s = have && (e.eidx == k);
            chk("strobe", d, {31'h0, strb[d]}, {31'h0, exp_s});
            if (exp_s) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                hd[d] = e.dat;
                hv[d] = e.vld;
                if (!e.vld && hc[d] < 255) hc[d]++;
            end
            chk("data", d, {24'h0, dout[d]}, {24'h0, hd[d]});
            chk("valid", d, {31'h0, vld[d]}, {31'h0, hv[d]});
            chk("active", d, {31'h0, act[d]}, {31'h0, (lock_e[d] >= 0 && k >= lock_e[d])});
        end
`ifdef SERPAR_BC_COUNT_EN
        chk("bc_count", d, {24'h0, bcc[d]}, hc[d]);
`endif
    endtask

    always begin
        logic r;
        @(posedge clk_32f);
        r = reset_L;
        #2;
        for (int d = 0; d < 2; d++) check_inst(d, r);
        k = r ? k + 1 : 0;
    end

    initial begin
        lock_e[0] = -1;
        lock_e[1] = -1;
        do_reset(3);

        add_bits(32'b101, 3);
        repeat (4) add_byte(COMMA);
        add_byte(8'h5A);
        add_byte(COMMA);
        add_byte(8'h12);
        add_byte(COMMA);
        play();

        do_reset(2);
        repeat (2) add_byte(COMMA);
        add_byte(8'h00);
        repeat (4) add_byte(COMMA);
        add_byte(8'h3C);
        add_byte(COMMA);
        add_byte(8'h77);
        play();

        do_reset(1);
        repeat (4) add_byte(COMMA);
        add_byte(8'h66);
        add_bits(32'hA, 4);
        play();
        do_reset(1);
        repeat (4) add_byte(COMMA);
        add_byte(8'hA5);
        add_byte(8'h11);
        play();

        for (int s = 0; s < 4; s++) begin
            do_reset(1);
            add_bits($urandom, $urandom_range(0, 15));
            repeat (4) add_byte(COMMA);
            for (int b = 0; b < 24; b++) begin
                if ($urandom_range(0, 9) < 3) add_byte(COMMA);
                else add_byte(8'($urandom));
            end
            play();
        end

        do_reset(1);
        repeat (4) add_byte(COMMA);
        repeat (300) add_byte(COMMA);
        add_byte(8'h42);
        play();

        do_reset(2);
        @(negedge clk_32f);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_par_1x8.md
Name: serial_par_1x8

Overview:
- Upstream neighbour of the 8-to-32 byte assembler.
- Receives a 1-bit serial stream at clk_32f, MSB first, and locks byte alignment by hunting for the comma byte.
- Presents aligned bytes plus a valid flag, each held for 8 clk_32f cycles so a clk_4f consumer can sample them.
- Idle periods on the link are carried as comma bytes; these are reported with valid_out=0.

Parameters:
- COMMA, 8'hBC, alignment/idle byte value.
- BC_LOCK_COUNT, 4, consecutive aligned commas (including the first detection) required to declare lock; legal range 1..7.

Ports:
- clk_32f  input  1  bit clock; all logic on its posedge.
- reset_L  input  1  synchronous, active-low reset.
- data_in  input  1  serial data, first bit of each byte = bit 7.
- data_out  output  8  last completed aligned byte.
- valid_out  output  1  1 when data_out is a non-comma byte received while locked.
- byte_strobe  output  1  one-cycle pulse on the edge data_out/valid_out update.
- active  output  1  1 while locked.

Behaviour:
- Internal state:
  - shift_reg[7:0] <= {shift_reg[6:0], data_in} every edge out of reset.
  - new_byte = {shift_reg[6:0], data_in}.
  - bit_cnt[2:0]; a byte completes on the edge where bit_cnt==7. bit_cnt wraps 7->0.
  - bc_cnt[2:0], comma count.
- Reset (reset_L==0 at edge): state=SEARCH; shift_reg, bit_cnt, bc_cnt, data_out, valid_out, byte_strobe, active all 0. Reset mid-stream discards partial bytes and lock; alignment restarts from SEARCH on the next edge.
- SEARCH:
  - Compare new_byte to COMMA on every edge (any bit alignment).
  - On match: bit_cnt<=0 (next bit begins a new byte) and bc_cnt<=1.
  - If BC_LOCK_COUNT==1, go directly to LOCKED with active<=1. Otherwise go to ALIGN.
- ALIGN: at byte completion:
  - If new_byte==COMMA: bc_cnt<=bc_cnt+1. When bc_cnt+1==BC_LOCK_COUNT, go to LOCKED with active<=1 on that edge.
  - If new_byte!=COMMA: go to SEARCH with bc_cnt<=0. The erroneous byte is not re-searched for a shifted comma on that edge.
- LOCKED: at each byte completion:
  - data_out<=new_byte.
  - valid_out<=(new_byte!=COMMA).
  - byte_strobe<=1 for one cycle.
  - Between completions, data_out and valid_out hold and byte_strobe=0.
  - Stays LOCKED until reset; no loss-of-sync detection.
- Output rules:
  - data_out, valid_out and byte_strobe stay 0 outside LOCKED.
  - The comma byte that achieves lock is not presented; the first presented byte is the next completed byte.
- Latency: bit 0 of a byte sampled at edge k -> data_out/valid_out/byte_strobe registered at edge k (visible after k), held through edge k+7.
- All outputs are registered; no combinational path from data_in to outputs.

Optional Feature:
- Macro SERPAR_BC_COUNT_EN.
- Defined:
  - Adds output bc_count[7:0].
  - Increments by 1 on each comma byte completed while LOCKED, saturating at 255.
  - Cleared by reset; stays 0 before lock.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - COMMA default (8'hBC).
  - State encoding SEARCH=2'd0, ALIGN=2'd1, LOCKED=2'd2.
  - BYTE_W=8.
- Single module; no sub-module is natural. Shift register, counters and FSM are small and tightly coupled.

Test Plan:
- Reset: hold reset_L=0 for 3 edges with random data_in -> all outputs 0, state SEARCH; release -> outputs remain 0 until lock.
- Lock with 3 garbage bits prepended: send bits 101, then 4x 8'hBC, then 8'h5A.
  - active rises on the edge completing the 4th BC.
  - Next byte 8'h5A appears with valid_out=1 and a single byte_strobe, held 8 cycles.
- Idle in lock: after lock send 8'hBC, 8'h12, 8'hBC.
  - valid_out sequence 0,1,0.
  - data_out sequence BC,12,BC.
  - byte_strobe every 8th edge exactly.
- Broken alignment: send 2x BC, then 8'h00, then 4x BC.
  - Returns to SEARCH after 8'h00; active only after the later 4 BCs.
  - No valid_out before then.
- Reset mid-lock: assert reset_L=0 one edge in the middle of byte 8'hA5.
  - All outputs 0 next edge.
  - Relock required (4 BCs) before any valid_out.
- SERPAR_BC_COUNT_EN (define set): lock, then send 300 BCs -> bc_count saturates at 255. BC_LOCK_COUNT=1 build: a single BC sets active.
